npu_out_arbiter: RTL and testbench
==================================

# npu_out_arbiter

Round-robin write arbiter for the NPU's shared 8-bit output FIFO. It sits between four 16-bit result producers (MAC/ReLU/comparator lanes) and the FIFO write port. It accepts one 16-bit word at a time over a valid/ready handshake and serializes it into two FIFO byte writes, stalling on FIFO full. It also keeps a running count of completed words for the top-level FSM and debug.

## Interface
- `MSB_FIRST`, default 1: 1 writes byte [15:8] first and [7:0] second; 0 swaps the order.
- `CLKEXT` in 1: the block's only clock; all state updates on the rising edge.
- `RST_GLO` in 1: reset, synchronous and active-low.
- `EN` in 1: arbitration enable. When 0, no new word is accepted; a word already in progress completes.
- `REQ_VALID` in 4: per-requester valid. Bit i belongs to requester i.
- `REQ_DATA` in 64: requester i's word is at [16i+15:16i]. It must hold stable while `REQ_VALID[i]` is high and `REQ_READY[i]` is low.
- `REQ_READY` out 4: combinational, one-hot or zero. A transfer happens on the edge where `REQ_VALID[i]` and `REQ_READY[i]` are both 1.
- `FIFO_FULL` in 1: full flag from the output FIFO.
- `FIFO_WF_EN` out 1: combinational FIFO write enable.
- `FIFO_DATA_IN` out 8: combinational FIFO write data. It is 8'h00 whenever `FIFO_WF_EN` is 0.
- `GRANT` out 2: registered index of the requester owning the current or last word.
- `BUSY` out 1: registered, 1 in WR_HI or WR_LO.
- `CLR_CNT` in 1: synchronous clear of `WORD_CNT`.
- `WORD_CNT` out 16: registered count of fully written words; wraps from 16'hFFFF to 0.

## Operation
**Registers**
- `state` ∈ {IDLE, WR_HI, WR_LO}.
- `hold[15:0]`: captured word.
- `rr_ptr[1:0]`: highest-priority requester.
- `GRANT`, `WORD_CNT`.

**Arbitration (`pick`)**
- Scan i = `rr_ptr`, `rr_ptr`+1, … (mod 4).
- The first i with `REQ_VALID[i]`=1 wins.
- No valid request means no pick.

**Accept condition (`acc`)**
- `acc` = `EN` & (any `REQ_VALID`) & (state==IDLE, or state==WR_LO & !`FIFO_FULL`).
- When `acc`=1, `REQ_READY[pick]`=1.
- On that edge: `hold` <= `REQ_DATA[pick]`, `GRANT` <= pick, state <= WR_HI.

**IDLE**
- No FIFO writes.
- If `acc`, go to WR_HI.
- Otherwise stay in IDLE.

**WR_HI**
- `FIFO_WF_EN` = !`FIFO_FULL`.
- Data = first byte of `hold`.
- On a write, go to WR_LO. Otherwise stall with `hold` unchanged.

**WR_LO**
- `FIFO_WF_EN` = !`FIFO_FULL`.
- Data = second byte of `hold`.
- On a write:
  - `WORD_CNT`++.
  - `rr_ptr` <= `GRANT`+1.
  - Next state is WR_HI if `acc`, else IDLE.
- For the same-cycle accept in WR_LO, `pick` scans from `GRANT`+1, not the stale `rr_ptr`.

**EN low mid-word**
- WR_HI and WR_LO continue to completion.
- The state then returns to IDLE and no further READY is asserted.

**CLR_CNT**
- `WORD_CNT` <= 0 on the edge.
- If it coincides with a WR_LO completion, the clear wins and the result is 0.

**Reset (`RST_GLO`=0 at an edge), from any state including mid-word**
- state=IDLE, `hold`=0, `rr_ptr`=0, `GRANT`=0, `WORD_CNT`=0, `BUSY`=0.
- A partially written word is abandoned; only its first byte stays in the FIFO.
- While `RST_GLO`=0, `REQ_READY`=0 and `FIFO_WF_EN`=0.

**Invariants**
- Never more than one `REQ_READY` bit set.
- `FIFO_WF_EN` is never 1 while `FIFO_FULL`=1.
- Every accepted word produces exactly two FIFO writes unless reset intervenes.

## Timing
- Reset values: `REQ_READY`=0, `FIFO_WF_EN`=0, `FIFO_DATA_IN`=8'h00, `GRANT`=0, `BUSY`=0, `WORD_CNT`=0.
- Latency:
  - Accept at edge T.
  - First byte written at edge T+1, second at T+2 (no full).
  - `WORD_CNT` updates at T+2.
- Throughput:
  - Isolated word: 3 cycles (IDLE, WR_HI, WR_LO).
  - Back-to-back words: 2 cycles per word, because accept overlaps the WR_LO write.
- Stall: each cycle `FIFO_FULL`=1 in WR_HI/WR_LO adds one cycle. No byte is dropped or duplicated.
- `BUSY` rises the cycle after accept and falls the cycle after the last write when no new accept occurs.

## Test plan
- **Reset:** hold `RST_GLO`=0 for 2 cycles with all `REQ_VALID`=4'hF → `REQ_READY`=0, `FIFO_WF_EN`=0, `GRANT`=0, `WORD_CNT`=0 throughout; after release, requester 0 is accepted first.
- **Single word:** requester 1 sends 16'hA55A, `MSB_FIRST`=1 → `REQ_READY`=4'b0010 for one cycle; writes 8'hA5 then 8'h5A on the next two edges; `WORD_CNT`=1; `GRANT`=1. With `MSB_FIRST`=0 the byte order is 8'h5A then 8'hA5.
- **Fairness:** all four valid continuously, `REQ_DATA` lane i = 16'h1111·(i+1) → grants 0,1,2,3,0,1… with 2 cycles per word after the first; FIFO stream 11,11,22,22,33,33,44,44,…
- **Full stall:** `FIFO_FULL`=1 for 3 cycles starting in WR_LO of 16'hBEEF → `FIFO_WF_EN`=0 for those 3 cycles; then a single 8'hEF write; exactly 2 writes total.
- **Reset mid-word:** `RST_GLO`=0 during WR_LO → next cycle state IDLE, no 2nd byte written, `WORD_CNT` unchanged at 0, `rr_ptr`=0.
- **EN and counter edges:**
  - `EN`=0 asserted in WR_HI → the word completes and no new READY follows.
  - `CLR_CNT`=1 coincident with a WR_LO write at `WORD_CNT`=5 → `WORD_CNT`=0.
  - Preload `WORD_CNT`=16'hFFFF, then complete one word → `WORD_CNT`=0.

Source files
------------

// File: rtl/npu_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : npu_out_arbiter
// Purpose  : Round-robin write arbiter in front of the NPU's shared 8-bit
//            output FIFO. Four 16-bit result producers compete for the FIFO.
//            The arbiter accepts one word at a time over valid/ready and
//            writes it to the FIFO as two bytes. It stalls while the FIFO is
//            full and counts the words it has fully written.
// Ports    : CLKEXT        - clock, rising edge
//            RST_GLO       - synchronous active-low reset
//            EN            - arbitration enable; a word in flight still completes
//            REQ_VALID[3:0]- per-requester valid
//            REQ_DATA[63:0]- requester i word at [16i+15:16i]
//            REQ_READY[3:0]- combinational, one-hot or zero
//            FIFO_FULL     - FIFO full flag
//            FIFO_WF_EN    - combinational FIFO write enable
//            FIFO_DATA_IN  - combinational FIFO write data (0 when not writing)
//            GRANT[1:0]    - registered owner of the current or last word
//            BUSY          - registered, high in WR_HI / WR_LO
//            CLR_CNT       - synchronous clear of WORD_CNT
//            WORD_CNT[15:0]- registered count of completed words, wraps
// Revision : 1.0 - initial release
// ============================================================================
module npu_out_arbiter #(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic        CLKEXT,
  input  logic        RST_GLO,
  input  logic        EN,
  input  logic [3:0]  REQ_VALID,
  input  logic [63:0] REQ_DATA,
  output logic [3:0]  REQ_READY,
  input  logic        FIFO_FULL,
  output logic        FIFO_WF_EN,
  output logic [7:0]  FIFO_DATA_IN,
  output logic [1:0]  GRANT,
  output logic        BUSY,
  input  logic        CLR_CNT,
  output logic [15:0] WORD_CNT
);

  localparam bit C_HI_FIRST = (MSB_FIRST != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_HI = 2'd1,
    ST_WR_LO = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic [1:0]  w_scan_base;
  logic [1:0]  w_pick;
  logic        w_any_valid;
  logic        w_acc;
  logic        w_wr;
  logic [7:0]  w_first_byte;
  logic [7:0]  w_second_byte;

  // When a new word is accepted in the same cycle the previous one completes,
  // rr_ptr has not yet been advanced, so the scan must start past the
  // current owner instead.
  assign w_scan_base = (state_q == ST_WR_LO) ? (grant_q + 2'd1) : rr_ptr_q;
  assign w_any_valid = |REQ_VALID;

  always_comb begin
    logic       found;
    logic [1:0] idx;
    w_pick = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = w_scan_base + 2'(k);
      if (!found && REQ_VALID[idx]) begin
        w_pick = idx;
        found  = 1'b1;
      end
    end
  end

  // RST_GLO gates the handshake and the FIFO write so nothing leaks while reset is held.
  assign w_acc = RST_GLO && EN && w_any_valid &&
                 ((state_q == ST_IDLE) || ((state_q == ST_WR_LO) && !FIFO_FULL));

  assign w_wr  = RST_GLO && !FIFO_FULL &&
                 ((state_q == ST_WR_HI) || (state_q == ST_WR_LO));

  assign w_first_byte  = C_HI_FIRST ? hold_q[15:8] : hold_q[7:0];
  assign w_second_byte = C_HI_FIRST ? hold_q[7:0]  : hold_q[15:8];

  assign REQ_READY    = w_acc ? (4'b0001 << w_pick) : 4'b0000;
  assign FIFO_WF_EN   = w_wr;
  assign FIFO_DATA_IN = !w_wr ? 8'h00 :
                        ((state_q == ST_WR_HI) ? w_first_byte : w_second_byte);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    word_cnt_d = word_cnt_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_WR_HI: begin
        if (!FIFO_FULL) begin
          state_d = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        if (!FIFO_FULL) begin
          word_cnt_d = word_cnt_q + 16'd1;
          rr_ptr_d   = grant_q + 2'd1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_acc) begin
      hold_d  = REQ_DATA[{w_pick, 4'd0} +: 16];
      grant_d = w_pick;
      state_d = ST_WR_HI;
    end

    // A clear beats a coincident completion.
    if (CLR_CNT) begin
      word_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge CLKEXT) begin
    if (!RST_GLO) begin
      state_q    <= ST_IDLE;
      hold_q     <= 16'd0;
      rr_ptr_q   <= 2'd0;
      grant_q    <= 2'd0;
      busy_q     <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      busy_q     <= (state_d != ST_IDLE);
      word_cnt_q <= word_cnt_d;
    end
  end

  assign GRANT    = grant_q;
  assign BUSY     = busy_q;
  assign WORD_CNT = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_npu_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_npu_out_arbiter
// Purpose  : Directed, table-driven bench for npu_out_arbiter. Two instances
//            share all inputs: one writes the high byte first, the other the
//            low byte first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npu_out_arbiter;

  logic        CLKEXT = 1'b0;
  logic        RST_GLO = 1'b0;
  logic        EN = 1'b0;
  logic [3:0]  REQ_VALID = 4'h0;
  logic [63:0] REQ_DATA = 64'h0;
  logic        FIFO_FULL = 1'b0;
  logic        CLR_CNT = 1'b0;

  logic [3:0]  w_ready_m, w_ready_l;
  logic        w_wf_m, w_wf_l;
  logic [7:0]  w_data_m, w_data_l;
  logic [1:0]  w_grant_m, w_grant_l;
  logic        w_busy_m, w_busy_l;
  logic [15:0] w_cnt_m, w_cnt_l;

  int checks = 0;
  int errors = 0;

  always #5 CLKEXT = ~CLKEXT;

  npu_out_arbiter #(.MSB_FIRST(1)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .EN(EN),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(w_ready_m),
    .FIFO_FULL(FIFO_FULL), .FIFO_WF_EN(w_wf_m), .FIFO_DATA_IN(w_data_m),
    .GRANT(w_grant_m), .BUSY(w_busy_m), .CLR_CNT(CLR_CNT), .WORD_CNT(w_cnt_m)
  );

  npu_out_arbiter #(.MSB_FIRST(0)) dut_lsb (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .EN(EN),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(w_ready_l),
    .FIFO_FULL(FIFO_FULL), .FIFO_WF_EN(w_wf_l), .FIFO_DATA_IN(w_data_l),
    .GRANT(w_grant_l), .BUSY(w_busy_l), .CLR_CNT(CLR_CNT), .WORD_CNT(w_cnt_l)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [3:0]  valid;
    logic [63:0] data;
    logic        full;
    logic        clr;
    logic [3:0]  exp_ready;
    logic        exp_wf;
    logic [7:0]  exp_dm;     // data expected from the high-byte-first instance
    logic [7:0]  exp_dl;     // data expected from the low-byte-first instance
    logic [1:0]  exp_grant;  // after the edge
    logic        exp_busy;   // after the edge
    logic [15:0] exp_cnt;    // after the edge
  } vec_t;

  localparam logic [63:0] D_F = 64'h4444_3333_2222_1111;
  localparam logic [63:0] D_S = 64'h4444_3333_A55A_1111;
  localparam logic [63:0] D_B = 64'hBEEF_3333_2222_1111;

  localparam int NV = 33;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rst_n, input logic en, input logic [3:0] valid,
    input logic [63:0] data, input logic full, input logic clr,
    input logic [3:0] ready, input logic wf, input logic [7:0] dm,
    input logic [7:0] dl, input logic [1:0] grant, input logic busy,
    input logic [15:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.valid = valid; v.data = data;
    v.full = full; v.clr = clr; v.exp_ready = ready; v.exp_wf = wf;
    v.exp_dm = dm; v.exp_dl = dl; v.exp_grant = grant; v.exp_busy = busy;
    v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge CLKEXT);
    RST_GLO   = v.rst_n;
    EN        = v.en;
    REQ_VALID = v.valid;
    REQ_DATA  = v.data;
    FIFO_FULL = v.full;
    CLR_CNT   = v.clr;
    #1;
    chk($sformatf("v%0d ready", idx), 64'(w_ready_m), 64'(v.exp_ready));
    chk($sformatf("v%0d wf_en", idx), 64'(w_wf_m), 64'(v.exp_wf));
    chk($sformatf("v%0d data", idx), 64'(w_data_m), 64'(v.exp_dm));
    chk($sformatf("v%0d lsb_ready", idx), 64'(w_ready_l), 64'(v.exp_ready));
    chk($sformatf("v%0d lsb_wf_en", idx), 64'(w_wf_l), 64'(v.exp_wf));
    chk($sformatf("v%0d lsb_data", idx), 64'(w_data_l), 64'(v.exp_dl));
    chk($sformatf("v%0d full_write", idx), 64'(w_wf_m && FIFO_FULL), 64'd0);
    @(posedge CLKEXT);
    #1;
    chk($sformatf("v%0d grant", idx), 64'(w_grant_m), 64'(v.exp_grant));
    chk($sformatf("v%0d busy", idx), 64'(w_busy_m), 64'(v.exp_busy));
    chk($sformatf("v%0d cnt", idx), 64'(w_cnt_m), 64'(v.exp_cnt));
    chk($sformatf("v%0d lsb_grant", idx), 64'(w_grant_l), 64'(v.exp_grant));
    chk($sformatf("v%0d lsb_busy", idx), 64'(w_busy_l), 64'(v.exp_busy));
    chk($sformatf("v%0d lsb_cnt", idx), 64'(w_cnt_l), 64'(v.exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t wv;
    //             rst en valid data full clr ready wf  dm     dl     gnt busy cnt
    // reset held with all requesters valid
    vecs[0]  = mk(0, 1, 4'hF, D_F, 0, 0, 4'h0, 0, 8'h00, 8'h00, 2'd0, 0, 16'd0);
    vecs[1]  = mk(0, 1, 4'hF, D_F, 0, 0, 4'h0, 0, 8'h00, 8'h00, 2'd0, 0, 16'd0);
    // requester 0 wins first after release
    vecs[2]  = mk(1, 1, 4'hF, D_F, 0, 0, 4'h1, 0, 8'h00, 8'h00, 2'd0, 1, 16'd0);
    vecs[3]  = mk(1, 1, 4'h0, D_F, 0, 0, 4'h0, 1, 8'h11, 8'h11, 2'd0, 1, 16'd0);
    vecs[4]  = mk(1, 1, 4'h0, D_F, 0, 0, 4'h0, 1, 8'h11, 8'h11, 2'd0, 0, 16'd1);
    // single word from requester 1: A55A
    vecs[5]  = mk(1, 1, 4'h2, D_S, 0, 0, 4'h2, 0, 8'h00, 8'h00, 2'd1, 1, 16'd1);
    vecs[6]  = mk(1, 1, 4'h0, D_S, 0, 0, 4'h0, 1, 8'hA5, 8'h5A, 2'd1, 1, 16'd1);
    vecs[7]  = mk(1, 1, 4'h0, D_S, 0, 0, 4'h0, 1, 8'h5A, 8'hA5, 2'd1, 0, 16'd2);
    // fairness: all valid, rotation from rr_ptr=2, back-to-back words
    vecs[8]  = mk(1, 1, 4'hF, D_F, 0, 0, 4'h4, 0, 8'h00, 8'h00, 2'd2, 1, 16'd2);
    vecs[9]  = mk(1, 1, 4'hF, D_F, 0, 0, 4'h0, 1, 8'h33, 8'h33, 2'd2, 1, 16'd2);
    vecs[10] = mk(1, 1, 4'hF, D_F, 0, 0, 4'h8, 1, 8'h33, 8'h33, 2'd3, 1, 16'd3);
    vecs[11] = mk(1, 1, 4'hF, D_F, 0, 0, 4'h0, 1, 8'h44, 8'h44, 2'd3, 1, 16'd3);
    vecs[12] = mk(1, 1, 4'hF, D_F, 0, 0, 4'h1, 1, 8'h44, 8'h44, 2'd0, 1, 16'd4);
    vecs[13] = mk(1, 1, 4'hF, D_F, 0, 0, 4'h0, 1, 8'h11, 8'h11, 2'd0, 1, 16'd4);
    vecs[14] = mk(1, 1, 4'hF, D_F, 0, 0, 4'h2, 1, 8'h11, 8'h11, 2'd1, 1, 16'd5);
    vecs[15] = mk(1, 1, 4'hF, D_F, 0, 0, 4'h0, 1, 8'h22, 8'h22, 2'd1, 1, 16'd5);
    // clear coincident with WR_LO completion at count 5
    vecs[16] = mk(1, 1, 4'hF, D_F, 0, 1, 4'h4, 1, 8'h22, 8'h22, 2'd2, 1, 16'd0);
    // EN dropped in WR_HI: word completes, no further READY
    vecs[17] = mk(1, 0, 4'hF, D_F, 0, 0, 4'h0, 1, 8'h33, 8'h33, 2'd2, 1, 16'd0);
    vecs[18] = mk(1, 0, 4'hF, D_F, 0, 0, 4'h0, 1, 8'h33, 8'h33, 2'd2, 0, 16'd1);
    vecs[19] = mk(1, 0, 4'hF, D_F, 0, 0, 4'h0, 0, 8'h00, 8'h00, 2'd2, 0, 16'd1);
    // full stall of 3 cycles in WR_LO of BEEF
    vecs[20] = mk(1, 1, 4'h8, D_B, 0, 0, 4'h8, 0, 8'h00, 8'h00, 2'd3, 1, 16'd1);
    vecs[21] = mk(1, 1, 4'h0, D_B, 0, 0, 4'h0, 1, 8'hBE, 8'hEF, 2'd3, 1, 16'd1);
    vecs[22] = mk(1, 1, 4'h0, D_B, 1, 0, 4'h0, 0, 8'h00, 8'h00, 2'd3, 1, 16'd1);
    vecs[23] = mk(1, 1, 4'hF, D_B, 1, 0, 4'h0, 0, 8'h00, 8'h00, 2'd3, 1, 16'd1);
    vecs[24] = mk(1, 1, 4'h0, D_B, 1, 0, 4'h0, 0, 8'h00, 8'h00, 2'd3, 1, 16'd1);
    vecs[25] = mk(1, 1, 4'h0, D_B, 0, 0, 4'h0, 1, 8'hEF, 8'hBE, 2'd3, 0, 16'd2);
    // reset during WR_LO abandons the second byte
    vecs[26] = mk(1, 1, 4'h1, D_F, 0, 0, 4'h1, 0, 8'h00, 8'h00, 2'd0, 1, 16'd2);
    vecs[27] = mk(1, 1, 4'h0, D_F, 0, 0, 4'h0, 1, 8'h11, 8'h11, 2'd0, 1, 16'd2);
    vecs[28] = mk(0, 1, 4'h0, D_F, 0, 0, 4'h0, 0, 8'h00, 8'h00, 2'd0, 0, 16'd0);
    vecs[29] = mk(1, 1, 4'h0, D_F, 0, 0, 4'h0, 0, 8'h00, 8'h00, 2'd0, 0, 16'd0);
    // rr_ptr back at 0: requester 0 wins with all valid
    vecs[30] = mk(1, 1, 4'hF, D_F, 0, 0, 4'h1, 0, 8'h00, 8'h00, 2'd0, 1, 16'd0);
    vecs[31] = mk(1, 1, 4'h0, D_F, 0, 0, 4'h0, 1, 8'h11, 8'h11, 2'd0, 1, 16'd0);
    vecs[32] = mk(1, 1, 4'h0, D_F, 0, 0, 4'h0, 1, 8'h11, 8'h11, 2'd0, 0, 16'd1);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
    end

    // Counter wrap: preload FFFF, complete one word from requester 1
    @(negedge CLKEXT);
    force dut.word_cnt_q = 16'hFFFF;
    force dut_lsb.word_cnt_q = 16'hFFFF;
    #1;
    release dut.word_cnt_q;
    release dut_lsb.word_cnt_q;
    #1;
    chk("wrap preload", 64'(w_cnt_m), 64'hFFFF);
    wv = mk(1, 1, 4'h2, D_S, 0, 0, 4'h2, 0, 8'h00, 8'h00, 2'd1, 1, 16'hFFFF);
    apply(wv, 100);
    wv = mk(1, 1, 4'h0, D_S, 0, 0, 4'h0, 1, 8'hA5, 8'h5A, 2'd1, 1, 16'hFFFF);
    apply(wv, 101);
    wv = mk(1, 1, 4'h0, D_S, 0, 0, 4'h0, 1, 8'h5A, 8'hA5, 2'd1, 0, 16'h0000);
    apply(wv, 102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
